// File: rtl/ceespu_dmem_bridge.sv
// Bridges the ceespu data-memory port to a req/ack external bus.
// Holds the core stalled until ack or timeout, then gives one DONE cycle.
module ceespu_dmem_bridge #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [15:0] I_dmemAddress,
  input  logic [31:0] I_dmemWData,
  input  logic        I_dmemE,
  input  logic [3:0]  I_dmemWe,
  output logic [31:0] O_dmemData,
  output logic        O_dmemBusy,
  output logic        O_mem_req,
  output logic [13:0] O_mem_addr,
  output logic [31:0] O_mem_wdata,
  output logic [3:0]  O_mem_be,
  output logic        O_mem_wr,
  input  logic        I_mem_ack,
  input  logic [31:0] I_mem_rdata,
  output logic        O_err
);

  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state;
  logic [CW-1:0] waitCnt;
  logic [CW-1:0] waitCntNext;
  logic          unusedAddrBits;

  // Byte offset within the word is meaningless on a word-wide bus.
  assign unusedAddrBits = ^I_dmemAddress[1:0];
  assign waitCntNext    = waitCnt + 1'b1;
  assign O_dmemBusy     = ((state == IDLE) && I_dmemE) || (state == WAIT);

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state       <= IDLE;
      waitCnt     <= '0;
      O_mem_req   <= 1'b0;
      O_mem_addr  <= '0;
      O_mem_wdata <= '0;
      O_mem_be    <= '0;
      O_mem_wr    <= 1'b0;
      O_dmemData  <= '0;
      O_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (I_dmemE) begin
            O_mem_addr  <= I_dmemAddress[15:2];
            O_mem_wdata <= I_dmemWData;
            O_mem_be    <= I_dmemWe;
            O_mem_wr    <= |I_dmemWe;
            O_mem_req   <= 1'b1;
            waitCnt     <= '0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          // Ack is checked first so a completion on the timeout cycle still counts.
          if (I_mem_ack) begin
            if (!O_mem_wr) O_dmemData <= I_mem_rdata;
            O_mem_req <= 1'b0;
            state     <= DONE;
          end else if (waitCntNext == TIMEOUT_C) begin
            if (!O_mem_wr) O_dmemData <= ERR_RDATA;
            O_err     <= 1'b1;
            O_mem_req <= 1'b0;
            waitCnt   <= waitCntNext;
            state     <= DONE;
          end else begin
            waitCnt <= waitCntNext;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
